// File: rtl/serial_adder_ctrl.sv
// Sequences a WIDTH-bit ripple addition through a shared 1-bit full-adder FSM,
// one bit per ISSUE/CLEAR pass, LSB first, with valid/ready on both sides.
module serial_adder_ctrl #(
  parameter int WIDTH   = 4,
  parameter int ADD_LAT = 2
) (
  input  logic             clk,
  input  logic             NRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy,
  output logic             add_start,
  output logic             add_rst,
  output logic             add_a,
  output logic             add_b,
  output logic             add_cin,
  input  logic             add_s,
  input  logic             add_cout
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int LATW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);
  localparam logic [LATW-1:0] LAT_LAST = LATW'(ADD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CLEAR, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d, idx_nxt;
  logic [LATW-1:0]   lat_q, lat_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              abort_q, abort_d;
  logic              capture;

  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_sum_q, out_sum_d;
  logic              out_cout_q, out_cout_d;
  logic              busy_q, busy_d;
  logic              add_start_q, add_start_d;
  logic              add_rst_q, add_rst_d;
  logic              add_a_q, add_a_d;
  logic              add_b_q, add_b_d;
  logic              add_cin_q, add_cin_d;

  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lat_d       = lat_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    abort_d     = abort_q;
    capture     = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    add_start_d = add_start_q;
    add_rst_d   = add_rst_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d         = in_a;
          b_d         = in_b;
          carry_d     = in_cin;
          idx_d       = '0;
          lat_d       = '0;
          abort_d     = 1'b0;
          state_d     = ISSUE;
          in_ready_d  = 1'b0;
          add_start_d = 1'b1;
          add_a_d     = in_a[0];
          add_b_d     = in_b[0];
          add_cin_d   = in_cin;
        end
      end
      ISSUE: begin
        lat_d = lat_q + 1'b1;
        // Abort takes precedence over a capture landing on the same edge.
        if (abort || lat_q == LAT_LAST) begin
          if (abort) begin
            abort_d = 1'b1;
          end else begin
            capture = 1'b1;
            carry_d = add_cout;
          end
          state_d     = CLEAR;
          add_start_d = 1'b0;
          add_rst_d   = 1'b1;
          add_a_d     = 1'b0;
          add_b_d     = 1'b0;
          add_cin_d   = 1'b0;
        end
      end
      CLEAR: begin
        add_rst_d = 1'b0;
        if (abort_q || abort) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end else if (idx_q == IDX_LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_sum_d   = sum_q;
          out_cout_d  = carry_q;
        end else begin
          idx_d       = idx_nxt;
          lat_d       = '0;
          state_d     = ISSUE;
          add_start_d = 1'b1;
          add_a_d     = a_q[idx_nxt];
          add_b_d     = b_q[idx_nxt];
          add_cin_d   = carry_q;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Each sum bit is written only on the capture edge of its own pass.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sum
      assign sum_d[gi] = (capture && (idx_q == IDXW'(gi))) ? add_s : sum_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!NRST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lat_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      abort_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      busy_q      <= 1'b0;
      add_start_q <= 1'b0;
      add_rst_q   <= 1'b0;
      add_a_q     <= 1'b0;
      add_b_q     <= 1'b0;
      add_cin_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      abort_q     <= abort_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      busy_q      <= busy_d;
      add_start_q <= add_start_d;
      add_rst_q   <= add_rst_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign busy      = busy_q;
  assign add_start = add_start_q;
  assign add_rst   = add_rst_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: a 1-bit adder model, directed operand
// vectors with hand-computed sums, and a negedge monitor popping expected results.
module tb_serial_adder_ctrl;

  localparam int WIDTH   = 4;
  localparam int ADD_LAT = 2;

  logic             clk = 1'b0;
  logic             NRST = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic             abort = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;
  logic             add_start;
  logic             add_rst;
  logic             add_a;
  logic             add_b;
  logic             add_cin;
  logic             add_s;
  logic             add_cout;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(WIDTH), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .NRST(NRST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy),
    .add_start(add_start), .add_rst(add_rst),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  // 1-bit adder model: results only valid once add_start has been seen ADD_LAT-1 edges.
  int model_cnt = 0;
  always @(posedge clk) model_cnt <= (add_start && !add_rst) ? model_cnt + 1 : 0;
  assign add_s    = (add_start && model_cnt >= ADD_LAT - 1) ? (add_a ^ add_b ^ add_cin) : 1'b0;
  assign add_cout = (add_start && model_cnt >= ADD_LAT - 1) ?
                    ((add_a & add_b) | (add_a & add_cin) | (add_b & add_cin)) : 1'b0;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
  } res_t;

  res_t exp_q[$];
  res_t exp_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_edge = 0;
  int   done_edge = -100;
  bit   gap_arm = 1'b0;
  int   gap_checks = 0;
  int   start_rises = 0;
  int   start_cycles = 0;
  int   rst_cycles = 0;
  int   cin_cnt = 0;
  logic [7:0] cin_hist = '0;
  logic prev_ov = 1'b0, prev_or = 1'b0, prev_start = 1'b0, prev_cout = 1'b0;
  logic [WIDTH-1:0] prev_sum = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: samples at negedge, one line per completed result.
  always @(negedge clk) begin
    if (!NRST) begin
      prev_ov    = 1'b0;
      prev_or    = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (add_start) start_cycles++;
      if (add_rst) rst_cycles++;
      if (add_start && !prev_start) begin
        start_rises++;
        cin_cnt++;
        cin_hist = {cin_hist[6:0], add_cin};
      end
      if (in_valid && in_ready) begin
        if (gap_arm) begin
          chk("b2b_gap", cyc + 1 - done_edge, 1);
          gap_checks++;
        end
        acc_edge = cyc + 1;
      end
      if (out_valid && !prev_ov) begin
        chk("latency", cyc - acc_edge, WIDTH * (ADD_LAT + 1));
        chk("valid_expected", (exp_q.size() > 0) ? 1 : 0, 1);
      end
      if (out_valid && prev_ov && !prev_or) begin
        chk("hold_sum", out_sum, prev_sum);
        chk("hold_cout", out_cout, prev_cout);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          $display("result: sum=%b cout=%b (expected sum=%b cout=%b)",
                   out_sum, out_cout, exp_e.sum, exp_e.cout);
          chk("out_sum", out_sum, exp_e.sum);
          chk("out_cout", out_cout, exp_e.cout);
        end
        done_edge = cyc + 1;
      end
      prev_ov    = out_valid;
      prev_or    = out_ready;
      prev_start = add_start;
      prev_sum   = out_sum;
      prev_cout  = out_cout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                      input bit expect_out, input logic [WIDTH-1:0] es, input logic ec);
    int n;
    if (expect_out) exp_q.push_back(res_t'({es, ec}));
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !busy && !out_valid) && n < 300) begin
      tick();
      n++;
    end
    if (busy || exp_q.size() != 0) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_rises(input int target);
    int   n;
    int   rises;
    logic p;
    rises = 1;
    p = add_start;
    n = 0;
    while (rises < target && n < 100) begin
      tick();
      if (add_start && !p) rises++;
      p = add_start;
      n++;
    end
    chk("bit_window_reached", rises, target);
  endtask

  initial begin
    int base_rises, base_cycles, base_rst, base_cin, n;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_start", add_start, 0);
    chk("rst_add_rst", add_rst, 0);
    chk("rst_out_sum", out_sum, 0);
    NRST = 1'b1;
    tick();

    // 0101 + 0011 -> 1000, four 2-cycle start windows and four clear pulses
    base_rises = start_rises; base_cycles = start_cycles; base_rst = rst_cycles;
    send(4'b0101, 4'b0011, 1'b0, 1'b1, 4'b1000, 1'b0);
    wait_idle();
    chk("start_windows", start_rises - base_rises, WIDTH);
    chk("start_cycles", start_cycles - base_cycles, WIDTH * ADD_LAT);
    chk("rst_pulses", rst_cycles - base_rst, WIDTH);

    // 1111 + 0001 -> 0000 carry 1
    send(4'b1111, 4'b0001, 1'b0, 1'b1, 4'b0000, 1'b1);
    wait_idle();

    // 1010 + 0101 + 1 -> 0000 carry 1, carry-in of every bit is 1
    base_cin = cin_cnt;
    send(4'b1010, 4'b0101, 1'b1, 1'b1, 4'b0000, 1'b1);
    wait_idle();
    chk("cin_count", cin_cnt - base_cin, WIDTH);
    chk("cin_sequence", cin_hist[3:0], 4'b1111);

    // Backpressure: result held for 5 cycles, new request refused
    out_ready = 1'b0;
    send(4'b0010, 4'b0011, 1'b0, 1'b1, 4'b0101, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("bp_valid_seen", out_valid, 1);
    in_a = 4'b1111; in_b = 4'b1111; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_busy", busy, 0);

    // Abort during bit 2
    send(4'b0110, 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0);
    wait_rises(3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_rst_pulse", add_rst, 1);
    chk("abort_start_low", add_start, 0);
    chk("abort_valid_low", out_valid, 0);
    tick();
    chk("abort_rst_single", add_rst, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_valid_never", out_valid, 0);
    send(4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0010, 1'b0);
    wait_idle();

    // Reset during bit 1 (carry 1 in flight)
    send(4'b0011, 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0);
    wait_rises(2);
    NRST = 1'b0;
    tick();
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ctrl", {add_start, add_rst, add_a, add_b, add_cin}, 0);
    chk("mid_rst_out", {out_valid, out_cout, out_sum}, 0);
    NRST = 1'b1;
    tick();
    send(4'b0111, 4'b0001, 1'b0, 1'b1, 4'b1000, 1'b0);
    wait_idle();

    // Back-to-back with in_valid held high
    exp_q.push_back(res_t'({4'b1000, 1'b0}));
    exp_q.push_back(res_t'({4'b0001, 1'b1}));
    in_a = 4'b0011; in_b = 4'b0100; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_a = 4'b1001; in_b = 4'b1000; in_cin = 1'b0;
    gap_arm = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    gap_arm = 1'b0;
    in_valid = 1'b0;
    wait_idle();
    chk("b2b_gap_seen", gap_checks, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequencer that runs a WIDTH-bit addition through the team's 1-bit full-adder state machine, one bit per pass, LSB first.
- Accepts parallel operands over a valid/ready handshake and drives the adder's start/rst/A/B/CIN controls.
- Samples S/COUT and chains each COUT into the next bit's CIN.
- Returns the WIDTH-bit sum and the final carry over a valid/ready handshake. Sits between the parallel requester and the single shared 1-bit adder.

Parameters:
- WIDTH, 4, operand/sum width in bits (>=1).
- ADD_LAT, 2, cycles add_start is held before S/COUT are sampled (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- NRST  input  1  synchronous active-low reset; sampled on rising clk edge.
- in_valid  input  1  operands valid.
- in_ready  output  1  controller can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in to bit 0.
- abort  input  1  abandon current operation.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  sum.
- out_cout  output  1  carry out of MSB.
- busy  output  1  high in any state other than IDLE.
- add_start  output  1  adder start.
- add_rst  output  1  adder return-to-idle pulse, active high.
- add_a  output  1  current A bit.
- add_b  output  1  current B bit.
- add_cin  output  1  current carry-in.
- add_s  input  1  adder sum bit.
- add_cout  input  1  adder carry-out.

Behaviour:
- Reset (NRST=0 at an edge): state=IDLE. All outputs 0 except in_ready=1. Internal bit index, latency counter, operand regs and result regs are cleared. Reset overrides every other input, including mid-operation.
- States: IDLE, ISSUE, CLEAR, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch in_a, in_b and in_cin; set bit index=0 and lat counter=0; go to ISSUE.
- ISSUE:
  - add_start=1; add_a=a_reg[idx], add_b=b_reg[idx], add_cin=carry_reg. These are registered and held stable for the whole ISSUE window.
  - The lat counter increments each cycle.
  - On the edge where lat counter==ADD_LAT-1: capture sum_reg[idx]<=add_s and carry_reg<=add_cout, then go to CLEAR.
- CLEAR:
  - Exactly 1 cycle: add_start=0, add_rst=1.
  - Next state: if idx==WIDTH-1, go to DONE; otherwise idx+1, lat counter=0, go to ISSUE.
- DONE:
  - out_valid=1, out_sum=sum_reg, out_cout=carry_reg, all held stable until out_ready=1.
  - On an edge with out_ready=1, go to IDLE. in_ready rises the next cycle, so there is no same-cycle accept.
- Cost and latency:
  - Each bit costs ADD_LAT+1 cycles.
  - out_valid first rises exactly WIDTH*(ADD_LAT+1) cycles after the accepting edge (12 cycles for the defaults).
- Handshake rules:
  - in_ready=0 and in_valid is ignored in ISSUE, CLEAR and DONE.
  - Outputs are registered; there are no combinational paths from inputs to outputs.
- Abort:
  - Abort in ISSUE: go to CLEAR with add_rst=1 for 1 cycle, then IDLE. out_valid stays 0 and the results are discarded.
  - Abort in CLEAR: go to IDLE after that cycle.
  - Abort in IDLE is ignored; in_valid wins.
  - Abort in DONE is ignored.
- Carry chain: carry_reg is seeded from in_cin. Bit i uses the carry produced by bit i-1. out_cout is the COUT of bit WIDTH-1.
- add_a, add_b and add_cin are 0 outside ISSUE.

Test Plan:
- WIDTH=4, ADD_LAT=2; bench adder model gives S=A^B^CIN and COUT=maj(A,B,CIN) valid ADD_LAT cycles after add_start. Drive in_a=0101, in_b=0011, cin=0 -> out_valid exactly 12 cycles after accept, out_sum=1000, out_cout=0. Four add_start windows of 2 cycles, each followed by one add_rst pulse.
- in_a=1111, in_b=0001, cin=0 -> out_sum=0000, out_cout=1. in_a=1010, in_b=0101, cin=1 -> out_sum=0000, out_cout=1. Check add_cin sequence 1,1,1,1 in the second case.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_sum/out_cout stable, in_ready=0, and a new in_valid is not accepted. out_ready=1 -> IDLE, and in_ready=1 the next cycle.
- Abort asserted during bit 2 ISSUE -> one add_rst pulse, then IDLE. out_valid never rises. A following request 0001+0001 returns 0010.
- NRST=0 mid-operation (bit 1) -> next cycle all outputs 0 and in_ready=1. A subsequent 0111+0001, cin=0 returns 1000, cout=0, with no stale carry.
- Back-to-back requests, in_valid held high and out_ready=1 -> second accept occurs one cycle after the DONE handshake, and both results are correct.
